// File: rtl/voice_mix_router_pkg.sv
// Shared types and helpers for the voice mixer: FSM encoding, pan bit positions,
// accumulator sizing, unity gain and peak-meter level mapping.
package voice_mix_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCALE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int PAN_L = 0;
  localparam int PAN_R = 1;

  // Wide enough for NUM_CH full-scale products at maximum gain with no wrap.
  function automatic int acc_w(input int sample_w, input int gain_w, input int num_ch);
    return sample_w + gain_w + 1 + $clog2(num_ch);
  endfunction

  function automatic int unity_gain(input int gain_w);
    return 1 << (gain_w - 1);
  endfunction

  // One step per octave over the top four magnitude bits; saturation pins the meter.
  function automatic logic [3:0] peak_level_of(input logic [3:0] top, input logic clipped);
    logic [3:0] lvl;
    lvl = 4'd0;
    if (clipped)     lvl = 4'd15;
    else if (top[3]) lvl = 4'd4;
    else if (top[2]) lvl = 4'd3;
    else if (top[1]) lvl = 4'd2;
    else if (top[0]) lvl = 4'd1;
    return lvl;
  endfunction

endpackage

// File: rtl/voice_mix_router_sat_shift.sv
// Drops the gain fraction bits (arithmetic shift, floor) and clamps to the output range.
// Combinational, no backpressure; sat flags any clamping.
module sat_shift
  import voice_mix_router_pkg::*;
#(
  parameter int IN_W  = 27,
  parameter int OUT_W = 16,
  parameter int SHIFT = 7
) (
  input  logic signed [IN_W-1:0]  acc,
  output logic signed [OUT_W-1:0] dat,
  output logic                    sat
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] shifted;

  assign shifted = acc >>> SHIFT;

  always_comb begin
    sat = 1'b0;
    dat = shifted[OUT_W-1:0];
    if (shifted > MAX_V) begin
      dat = MAX_V[OUT_W-1:0];
      sat = 1'b1;
    end else if (shifted < MIN_V) begin
      dat = MIN_V[OUT_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/voice_mix_router.sv
// N-channel gain/pan mixer, one channel MAC per clock; out_ready NUM_CH+2 clocks after in_ready.
// No backpressure: in_ready while busy drops the frame and sets sticky overrun. Option: VOICE_MIX_PEAK_METER_EN.
module voice_mix_router
  import voice_mix_router_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int SAMPLE_W   = 16,
  parameter int GAIN_W     = 8,
  parameter int PEAK_DECAY = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_ready,
  input  logic [NUM_CH*SAMPLE_W-1:0]   samples_in,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_CH)-1:0]    cfg_ch,
  input  logic [GAIN_W-1:0]            cfg_gain,
  input  logic [1:0]                   cfg_pan,
  output logic [SAMPLE_W-1:0]          out_l,
  output logic [SAMPLE_W-1:0]          out_r,
  output logic                         out_ready,
  output logic                         clip,
  output logic                         busy,
  output logic                         overrun,
  output logic [3:0]                   peak_level
);

  localparam int IDX_W  = $clog2(NUM_CH);
  localparam int ACC_W  = acc_w(SAMPLE_W, GAIN_W, NUM_CH);
  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(GAIN_W));

  state_t state, state_nxt;

  logic [IDX_W-1:0]           idx;
  logic [GAIN_W-1:0]          gain    [NUM_CH];
  logic [1:0]                 pan     [NUM_CH];
  logic [GAIN_W-1:0]          gain_sh [NUM_CH];
  logic [1:0]                 pan_sh  [NUM_CH];
  logic signed [SAMPLE_W-1:0] samp    [NUM_CH];
  logic signed [ACC_W-1:0]    acc_l, acc_r;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [SAMPLE_W-1:0] sat_l, sat_r;
  logic                       sat_flag_l, sat_flag_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (in_ready) state_nxt = ST_ACCUM;
      ST_ACCUM: if (idx == IDX_W'(NUM_CH - 1)) state_nxt = ST_SCALE;
      ST_SCALE: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // Live settings; the frame in flight only ever sees its shadow copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        gain[i] <= UNITY;
        pan[i]  <= 2'b11;
      end
    end else if (cfg_we && (int'(cfg_ch) < NUM_CH)) begin
      gain[cfg_ch] <= cfg_gain;
      pan[cfg_ch]  <= cfg_pan;
    end
  end

  assign prod     = samp[idx] * $signed({1'b0, gain_sh[idx]});
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        samp[i]    <= '0;
        gain_sh[i] <= UNITY;
        pan_sh[i]  <= 2'b11;
      end
      idx   <= '0;
      acc_l <= '0;
      acc_r <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_ready) begin
            for (int i = 0; i < NUM_CH; i++) begin
              samp[i]    <= samples_in[i*SAMPLE_W +: SAMPLE_W];
              gain_sh[i] <= gain[i];
              pan_sh[i]  <= pan[i];
            end
            idx   <= '0;
            acc_l <= '0;
            acc_r <= '0;
          end
        end
        ST_ACCUM: begin
          if (pan_sh[idx][PAN_L]) acc_l <= acc_l + prod_ext;
          if (pan_sh[idx][PAN_R]) acc_r <= acc_r + prod_ext;
          idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  sat_shift #(.IN_W(ACC_W), .OUT_W(SAMPLE_W), .SHIFT(GAIN_W-1)) u_sat_l (
    .acc (acc_l),
    .dat (sat_l),
    .sat (sat_flag_l)
  );

  sat_shift #(.IN_W(ACC_W), .OUT_W(SAMPLE_W), .SHIFT(GAIN_W-1)) u_sat_r (
    .acc (acc_r),
    .dat (sat_r),
    .sat (sat_flag_r)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_l     <= '0;
      out_r     <= '0;
      out_ready <= 1'b0;
      clip      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_ready <= 1'b0;
      clip      <= 1'b0;
      if (state == ST_DONE) begin
        out_l     <= sat_l;
        out_r     <= sat_r;
        out_ready <= 1'b1;
        clip      <= sat_flag_l | sat_flag_r;
      end
      if (in_ready && state != ST_IDLE) overrun <= 1'b1;
    end
  end

`ifdef VOICE_MIX_PEAK_METER_EN
  localparam int DEC_W = $clog2(PEAK_DECAY) + 1;

  logic [DEC_W-1:0]    frame_cnt;
  logic [3:0]          peak_q, level, decayed;
  logic [SAMPLE_W-1:0] mag_l, mag_r, mag_max;
  logic                decay_tick;

  // The most negative code has no positive twin; fold it onto full scale.
  function automatic logic [SAMPLE_W-1:0] mag(input logic signed [SAMPLE_W-1:0] x);
    logic [SAMPLE_W-1:0] m;
    m = x;
    if (x[SAMPLE_W-1]) begin
      if (x == {1'b1, {(SAMPLE_W-1){1'b0}}}) m = {1'b0, {(SAMPLE_W-1){1'b1}}};
      else                                    m = -x;
    end
    return m;
  endfunction

  always_comb begin
    mag_l      = mag(sat_l);
    mag_r      = mag(sat_r);
    mag_max    = (mag_l > mag_r) ? mag_l : mag_r;
    level      = peak_level_of(mag_max[SAMPLE_W-2 -: 4], sat_flag_l | sat_flag_r);
    decay_tick = (frame_cnt == DEC_W'(PEAK_DECAY - 1));
    decayed    = (decay_tick && peak_q != 4'd0) ? peak_q - 4'd1 : peak_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      peak_q    <= 4'd0;
    end else if (state == ST_DONE) begin
      frame_cnt <= decay_tick ? '0 : frame_cnt + 1'b1;
      peak_q    <= (level > decayed) ? level : decayed;
    end
  end

  assign peak_level = peak_q;
`else
  logic unused_peak_decay;
  assign unused_peak_decay = ^PEAK_DECAY;
  assign peak_level        = 4'b0000;
`endif

endmodule

// File: tb/tb_voice_mix_router.sv
// Randomized bench for voice_mix_router with a frame-level mixing model and directed literal cases.
module tb_voice_mix_router;

  localparam int NUM_CH     = 4;
  localparam int SAMPLE_W   = 16;
  localparam int GAIN_W     = 8;
  localparam int PEAK_DECAY = 1024;
  localparam int LAT        = NUM_CH + 2;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       in_ready = 1'b0;
  logic [NUM_CH*SAMPLE_W-1:0] samples_in = '0;
  logic                       cfg_we = 1'b0;
  logic [1:0]                 cfg_ch = '0;
  logic [GAIN_W-1:0]          cfg_gain = '0;
  logic [1:0]                 cfg_pan = '0;
  logic [SAMPLE_W-1:0]        out_l, out_r;
  logic                       out_ready, clip, busy, overrun;
  logic [3:0]                 peak_level;

  voice_mix_router #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .GAIN_W(GAIN_W), .PEAK_DECAY(PEAK_DECAY)
  ) dut (
    .clk(clk), .reset(reset), .in_ready(in_ready), .samples_in(samples_in),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_gain(cfg_gain), .cfg_pan(cfg_pan),
    .out_l(out_l), .out_r(out_r), .out_ready(out_ready), .clip(clip),
    .busy(busy), .overrun(overrun), .peak_level(peak_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: frame-level view of the mixer.
  int  m_gain [NUM_CH];
  int  m_pan  [NUM_CH];
  int  f_s    [NUM_CH];
  int  f_g    [NUM_CH];
  int  f_p    [NUM_CH];
  bit  m_busy = 0;
  bit  was_busy;
  int  m_cnt = 0;
  bit  m_ovr = 0;
  int  m_l = 0, m_r = 0;
  bit  m_rdy = 0, m_clip = 0;
  int  m_peak = 0, m_nf = 0;

  function automatic longint scale_sat(input longint acc, output bit s);
    longint v;
    v = acc >>> (GAIN_W - 1);
    s = 0;
    if (v > 32767)       begin v = 32767;  s = 1; end
    else if (v < -32768) begin v = -32768; s = 1; end
    return v;
  endfunction

  function automatic int meter(input int l, input int r, input bit clipped);
    int al, ar, m;
    al = (l < 0) ? -l : l;
    ar = (r < 0) ? -r : r;
    if (al > 32767) al = 32767;
    if (ar > 32767) ar = 32767;
    m = (al > ar) ? al : ar;
    if (clipped)       return 15;
    if (m >= 16384)    return 4;
    if (m >= 8192)     return 3;
    if (m >= 4096)     return 2;
    if (m >= 2048)     return 1;
    return 0;
  endfunction

  task automatic finish_frame();
    longint al, ar;
    bit sl, sr;
    int lvl;
    al = 0;
    ar = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (f_p[i] & 1) al += longint'(f_s[i]) * f_g[i];
      if (f_p[i] & 2) ar += longint'(f_s[i]) * f_g[i];
    end
    m_l    = int'(scale_sat(al, sl));
    m_r    = int'(scale_sat(ar, sr));
    m_clip = sl | sr;
    m_rdy  = 1;
`ifdef VOICE_MIX_PEAK_METER_EN
    m_nf++;
    if ((m_nf % PEAK_DECAY) == 0 && m_peak > 0) m_peak--;
    lvl = meter(m_l, m_r, m_clip);
    if (lvl > m_peak) m_peak = lvl;
`else
    lvl = 0;
`endif
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_cnt = 0; m_ovr = 0; m_l = 0; m_r = 0;
      m_rdy = 0; m_clip = 0; m_peak = 0; m_nf = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_gain[i] = 128;
        m_pan[i]  = 3;
      end
    end else begin
      was_busy = m_busy;
      m_rdy    = 0;
      m_clip   = 0;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == LAT) begin
          m_busy = 0;
          finish_frame();
        end
      end
      if (in_ready) begin
        if (was_busy) m_ovr = 1;
        else begin
          m_busy = 1;
          m_cnt  = 0;
          for (int i = 0; i < NUM_CH; i++) begin
            f_s[i] = int'($signed(samples_in[i*SAMPLE_W +: SAMPLE_W]));
            f_g[i] = m_gain[i];
            f_p[i] = m_pan[i];
          end
        end
      end
      if (cfg_we) begin
        m_gain[cfg_ch] = int'(cfg_gain);
        m_pan[cfg_ch]  = int'(cfg_pan);
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    check("out_l",      longint'($signed(out_l)), longint'(m_l));
    check("out_r",      longint'($signed(out_r)), longint'(m_r));
    check("out_ready",  longint'(out_ready), longint'(m_rdy));
    check("clip",       longint'(clip),      longint'(m_clip));
    check("busy",       longint'(busy),      longint'(m_busy));
    check("overrun",    longint'(overrun),   longint'(m_ovr));
    check("peak_level", longint'(peak_level), longint'(m_peak));
  endtask

  // Every cycle passes through here: sample on the falling edge, then the caller drives.
  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  int cap_l, cap_r, cap_clip, cap_peak;

  task automatic send(input logic [NUM_CH*SAMPLE_W-1:0] v);
    samples_in = v;
    in_ready   = 1'b1;
    tick();
    in_ready   = 1'b0;
  endtask

  task automatic cfg(input int ch, input int g, input int p);
    cfg_we   = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_gain = 8'(g);
    cfg_pan  = 2'(p);
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Watches up to cycle 12 after the accepting edge; lat = first out_ready cycle or -1.
  task automatic wait_out(input int done_ticks, output int lat, output int pulses);
    lat    = -1;
    pulses = 0;
    for (int k = done_ticks + 1; k <= 12; k++) begin
      tick();
      if (out_ready) begin
        pulses++;
        if (lat < 0) begin
          lat      = k;
          cap_l    = int'($signed(out_l));
          cap_r    = int'($signed(out_r));
          cap_clip = int'(clip);
          cap_peak = int'(peak_level);
        end
      end
    end
  endtask

  function automatic logic [NUM_CH*SAMPLE_W-1:0] pack4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  initial begin
    int lat, pulses;
    int r;
    logic [NUM_CH*SAMPLE_W-1:0] v;

    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_out_l",   longint'(out_l), 0);
    check("rst_busy",    longint'(busy), 0);
    check("rst_overrun", longint'(overrun), 0);

    // 1: unity gains, both pans
    send(pack4(1000, -2000, 300, 0));
    wait_out(0, lat, pulses);
    check("t1_latency", lat, LAT);
    check("t1_l", cap_l, -700);
    check("t1_r", cap_r, -700);
    check("t1_clip", cap_clip, 0);

    // 2: hot single channel left only
    cfg(0, 255, 1);
    cfg(1, 128, 0);
    cfg(2, 128, 0);
    cfg(3, 128, 0);
    send(pack4(32767, 1234, -555, 77));
    wait_out(0, lat, pulses);
    check("t2_l", cap_l, 32767);
    check("t2_r", cap_r, 0);
    check("t2_clip", cap_clip, 1);

    // 3: negative full scale on every channel
    do_reset();
    send(pack4(-32768, -32768, -32768, -32768));
    wait_out(0, lat, pulses);
    check("t3_l", cap_l, -32768);
    check("t3_r", cap_r, -32768);
    check("t3_clip", cap_clip, 1);
`ifdef VOICE_MIX_PEAK_METER_EN
    check("t3_peak", cap_peak, 15);
`else
    check("t3_peak", cap_peak, 0);
`endif

    // 4: second strobe three cycles in is dropped
    do_reset();
    send(pack4(1, 2, 3, 4));
    tick();
    tick();
    send(pack4(5000, 5000, 5000, 5000));
    wait_out(3, lat, pulses);
    check("t4_latency", lat, LAT);
    check("t4_pulses", pulses, 1);
    check("t4_l", cap_l, 10);
    check("t4_overrun", longint'(overrun), 1);
    for (int i = 0; i < 5; i++) tick();
    check("t4_overrun_sticky", longint'(overrun), 1);

    // 5: same-cycle config write lands after the snapshot
    samples_in = pack4(100, 200, 300, 400);
    in_ready = 1'b1;
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_gain = 8'd0; cfg_pan = 2'b11;
    tick();
    in_ready = 1'b0;
    cfg_we = 1'b0;
    wait_out(0, lat, pulses);
    check("t5_first", cap_l, 1000);
    send(pack4(100, 200, 300, 400));
    wait_out(0, lat, pulses);
    check("t5_second", cap_l, 800);

    // 6: reset mid-frame aborts it
    send(pack4(1000, -2000, 300, 0));
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("t6_out_l", longint'(out_l), 0);
    check("t6_busy", longint'(busy), 0);
    check("t6_overrun", longint'(overrun), 0);
    reset = 1'b0;
    wait_out(0, lat, pulses);
    check("t6_no_out", pulses, 0);
    send(pack4(1, 1, 1, 1));
    wait_out(0, lat, pulses);
    check("t6_after", cap_l, 4);

    // Random traffic: overlapping strobes, live config churn, occasional extremes.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r = $urandom_range(0, 5);
        if (r == 0)      v[c*SAMPLE_W +: SAMPLE_W] = 16'h7fff;
        else if (r == 1) v[c*SAMPLE_W +: SAMPLE_W] = 16'h8000;
        else             v[c*SAMPLE_W +: SAMPLE_W] = 16'($urandom);
      end
      samples_in = v;
      in_ready   = ($urandom_range(0, 6) == 0);
      cfg_we     = ($urandom_range(0, 4) == 0);
      cfg_ch     = 2'($urandom_range(0, NUM_CH - 1));
      cfg_gain   = 8'($urandom);
      cfg_pan    = 2'($urandom);
      tick();
    end
    in_ready = 1'b0;
    cfg_we   = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
